// File: rtl/instr_encoder_writer.sv
// RV32I field-to-word encoder that streams packed instructions into consecutive
// instruction-memory words; used to load programs before the core starts fetching.
module instr_encoder_writer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_req_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_full;
    logic                r_done;
    logic                r_err;
    logic                w_hs;
    logic                w_legal;
    logic                w_arm;
    logic                w_fin;
    logic [ADDR_W:0]     w_count_inc;

    // Pack decoded fields into an RV32I word; B/J drop imm[0] by construction.
    function automatic logic [31:0] encode(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] w;
        case (f)
            3'd0:    w = {f7, s2, s1, f3, d, op};
            3'd1:    w = {im[11:0], s1, f3, d, op};
            3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op};
            3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            3'd4:    w = {im[31:12], d, op};
            3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign w_hs        = req_valid & r_req_ready;
    assign w_legal     = (fmt <= 3'd5);
    assign w_arm       = start & (r_state != S_WRITE);
    assign w_fin       = finish & ~start & ((r_state == S_READY) | (r_state == S_FULL));
    assign w_count_inc = r_count + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state selection: start beats finish, finish beats a same-cycle handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READY;
                else       w_next = S_IDLE;
            end
            S_READY: begin
                if (start)                 w_next = S_READY;
                else if (finish)           w_next = S_IDLE;
                else if (w_hs && w_legal)  w_next = S_WRITE;
                else                       w_next = S_READY;
            end
            S_WRITE: begin
                if (w_count_inc == CNT_MAX) w_next = S_FULL;
                else                        w_next = S_READY;
            end
            S_FULL: begin
                if (start)       w_next = S_READY;
                else if (finish) w_next = S_IDLE;
                else             w_next = S_FULL;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, strobes and the address/count/word registers behind every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_READY);
            r_we        <= (w_next == S_WRITE);
            r_done      <= w_fin;
            if (w_arm) begin
                r_addr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end else if (r_state == S_WRITE) begin
                r_addr  <= (r_addr == ADDR_LAST) ? '0 : r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_count <= w_count_inc;
                r_full  <= (w_count_inc == CNT_MAX);
            end else if ((r_state == S_READY) && !finish && w_hs) begin
                if (w_legal) r_wdata <= encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                else         r_err   <= 1'b1;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign count       = r_count;
    assign full        = r_full;
    assign done        = r_done;
    assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Randomized and directed bench for instr_encoder_writer, checked every cycle
// against a transaction-level reference model of the load sequencer.
module tb_instr_encoder_writer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        fmt = 3'd0;
    logic [6:0]        opcode = 7'd0;
    logic [4:0]        rd = 5'd0;
    logic [4:0]        rs1 = 5'd0;
    logic [4:0]        rs2 = 5'd0;
    logic [2:0]        funct3 = 3'd0;
    logic [6:0]        funct7 = 7'd0;
    logic [31:0]       imm = 32'd0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: loader armed?, write pending?, stopped at capacity?
    bit          m_on = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_cap = 1'b0;
    int          m_addr = 0;
    int          m_count = 0;
    bit          m_err = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_wdata = 32'd0;

    instr_encoder_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Instruction word from field positions expressed as shifts and masks.
    function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                            input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] o, dd, a, b, c3, c7;
        o = 32'(op); dd = 32'(d) << 7; a = 32'(s1) << 15; b = 32'(s2) << 20;
        c3 = 32'(f3) << 12; c7 = 32'(f7) << 25;
        case (f)
            3'd0: return c7 | b | a | c3 | dd | o;
            3'd1: return ((im & 32'hFFF) << 20) | a | c3 | dd | o;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | b | a | c3 | ((im & 32'h1F) << 7) | o;
            3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | b | a | c3
                         | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
            3'd4: return (im & 32'hFFFFF000) | dd | o;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | dd | o;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update on the same edge the design samples its inputs.
    always @(posedge clk or negedge rst_n) begin : model
        bit t_on, t_wr, t_cap, t_err, t_done, t_rdy;
        int t_addr, t_count;
        logic [31:0] t_wdata;
        if (!rst_n) begin
            m_on <= 1'b0; m_wr <= 1'b0; m_cap <= 1'b0; m_addr <= 0; m_count <= 0;
            m_err <= 1'b0; m_done <= 1'b0; m_wdata <= 32'd0;
        end else begin
            t_on = m_on; t_wr = m_wr; t_cap = m_cap; t_err = m_err; t_addr = m_addr;
            t_count = m_count; t_wdata = m_wdata; t_done = 1'b0;
            t_rdy = m_on && !m_wr && !m_cap;
            if (t_wr) begin
                t_wr = 1'b0;
                t_addr = (t_addr + 1) % DEPTH;
                t_count = t_count + 1;
                if (t_count == DEPTH) t_cap = 1'b1;
            end else if (start) begin
                t_on = 1'b1; t_cap = 1'b0; t_addr = 0; t_count = 0; t_err = 1'b0;
            end else if (finish && t_on) begin
                t_on = 1'b0; t_cap = 1'b0; t_done = 1'b1;
            end else if (t_rdy && req_valid) begin
                if (fmt < 3'd6) begin
                    t_wdata = ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                    t_wr = 1'b1;
                end else begin
                    t_err = 1'b1;
                end
            end
            m_on <= t_on; m_wr <= t_wr; m_cap <= t_cap; m_err <= t_err; m_addr <= t_addr;
            m_count <= t_count; m_wdata <= t_wdata; m_done <= t_done;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",   32'(req_ready),   32'(m_on && !m_wr && !m_cap));
            chk("imem_we",     32'(imem_we),     32'(m_wr));
            chk("imem_addr",   32'(imem_addr),   32'(m_addr));
            chk("imem_wdata",  imem_wdata,       m_wdata);
            chk("count",       32'(count),       32'(m_count));
            chk("full",        32'(full),        32'(m_count == DEPTH));
            chk("done",        32'(done),        32'(m_done));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        @(negedge clk);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL handshake_timeout: req_ready never seen, expected within 20 cycles");
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        chk("enc_R", ref_enc(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0), 32'h002081B3);
        chk("enc_I", ref_enc(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 32'h00500093);
        chk("enc_S", ref_enc(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), 32'h0020A423);
        chk("enc_B", ref_enc(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC), 32'hFE000EE3);
        chk("enc_J", ref_enc(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8), 32'h008000EF);
        chk("enc_U", ref_enc(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), 32'h123452B7);

        pulse_start();
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("R_we", 32'(imem_we), 32'd1);
        chk("R_addr", 32'(imem_addr), 32'd0);
        chk("R_word", imem_wdata, 32'h002081B3);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("I_word", imem_wdata, 32'h00500093);
        chk("I_addr", 32'(imem_addr), 32'd1);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        chk("S_word", imem_wdata, 32'h0020A423);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        chk("B_word", imem_wdata, 32'hFE000EE3);
        chk("B_addr", 32'(imem_addr), 32'd3);
        @(negedge clk);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        pulse_start();
        chk("rearm_addr", 32'(imem_addr), 32'd0);
        chk("rearm_count", 32'(count), 32'd0);
        chk("rearm_full", 32'(full), 32'd0);

        send(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_we", 32'(imem_we), 32'd0);
        chk("illegal_addr", 32'(imem_addr), 32'd0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        chk("J_word", imem_wdata, 32'h008000EF);
        chk("J_addr", 32'(imem_addr), 32'd0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        chk("U_word", imem_wdata, 32'h123452B7);
        chk("U_addr", 32'(imem_addr), 32'd1);

        @(negedge clk);
        req_valid = 1'b1; finish = 1'b1; fmt = 3'd0;
        @(negedge clk);
        req_valid = 1'b0; finish = 1'b0;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_we", 32'(imem_we), 32'd0);
        chk("fin_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("fin_done_clr", 32'(done), 32'd0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 39) == 0);
            finish    = ($urandom_range(0, 29) == 0);
            req_valid = 1'($urandom_range(0, 1));
            fmt       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            opcode    = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            funct3    = 3'($urandom); funct7 = 7'($urandom); imm = 32'($urandom);
        end
        @(negedge clk);
        start = 1'b0; finish = 1'b0; req_valid = 1'b0;

        pulse_start();
        send(3'd1, 7'h13, 5'd7, 5'd2, 5'd0, 3'd0, 7'd0, 32'd9);
        chk("prerst_we", 32'(imem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(imem_we), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_wdata", imem_wdata, 32'd0);
        chk("rst_mid_addr", 32'(imem_addr), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
